// File: rtl/mem_data_access.sv
// Memory-access stage: turns the EX effective address into one SRAM-like data
// transaction, checks alignment, and returns extended load data to writeback.
module mem_data_access (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_store_data,
    input  logic [2:0]  in_mem_op,
    input  logic        in_flush,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic        out_adel,
    output logic        out_ades,
    output logic [31:0] out_badvaddr
);

    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LBU = 3'd1;
    localparam logic [2:0] OP_LH  = 3'd2;
    localparam logic [2:0] OP_LHU = 3'd3;
    localparam logic [2:0] OP_LW  = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SW  = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic        cancel, cancel_nxt;
    logic        accept, capture;

    logic [31:0] addr_p0;
    logic [31:0] st_p0;
    logic [2:0]  op_p0;
    logic        fault_p0;
    logic [31:0] rdata_p0;
    logic        is_store_p0;

    function automatic logic misaligned(input logic [2:0] op, input logic [1:0] lo);
        case (op)
            OP_LH, OP_LHU, OP_SH: misaligned = lo[0];
            OP_LW, OP_SW:         misaligned = |lo;
            default:              misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] size_of(input logic [2:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: size_of = 2'd0;
            OP_LH, OP_LHU, OP_SH: size_of = 2'd1;
            default:              size_of = 2'd2;
        endcase
    endfunction

    // The bus picks the active lane from data_addr, so every lane carries the datum.
    function automatic logic [31:0] replicate(input logic [2:0] op, input logic [31:0] st);
        case (op)
            OP_SB:   replicate = {4{st[7:0]}};
            OP_SH:   replicate = {2{st[15:0]}};
            default: replicate = st;
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [2:0] op, input logic [1:0] lo,
                                            input logic [31:0] word);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = word[8*lo +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (op)
            OP_LB:   extract = {{24{b[7]}}, b};
            OP_LBU:  extract = {24'd0, b};
            OP_LH:   extract = {{16{h[15]}}, h};
            OP_LHU:  extract = {16'd0, h};
            default: extract = word;
        endcase
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            cancel <= 1'b0;
        end else begin
            state  <= state_nxt;
            cancel <= cancel_nxt;
        end
    end

    // Datapath registers are only observed through state-gated outputs.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_p0  <= in_alu_result;
            st_p0    <= in_store_data;
            op_p0    <= in_mem_op;
            fault_p0 <= misaligned(in_mem_op, in_alu_result[1:0]);
        end
        if (capture) begin
            rdata_p0 <= data_rdata;
        end
    end

    always_comb begin
        state_nxt  = state;
        cancel_nxt = cancel;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && !in_flush) begin
                    accept    = 1'b1;
                    state_nxt = misaligned(in_mem_op, in_alu_result[1:0]) ? DONE : REQ;
                end
            end
            REQ: begin
                if (data_addr_ok) begin
                    if (data_data_ok) begin
                        if (in_flush) begin
                            state_nxt = IDLE;
                        end else begin
                            state_nxt = DONE;
                            capture   = 1'b1;
                        end
                    end else begin
                        // Bus owns the transaction now; a flush must wait it out.
                        state_nxt  = WAIT;
                        cancel_nxt = in_flush;
                    end
                end else if (in_flush) begin
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (data_data_ok) begin
                    cancel_nxt = 1'b0;
                    if (cancel || in_flush) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = DONE;
                        capture   = 1'b1;
                    end
                end else if (in_flush) begin
                    cancel_nxt = 1'b1;
                end
            end
            DONE: begin
                if (in_flush || out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign is_store_p0 = (op_p0 > OP_LW);
    assign in_ready    = (state == IDLE);

    // Bus side
    assign data_req   = (state == REQ);
    assign data_wr    = data_req && is_store_p0;
    assign data_size  = data_req ? size_of(op_p0) : 2'd0;
    assign data_addr  = data_req ? addr_p0 : 32'd0;
    assign data_wdata = data_req ? replicate(op_p0, st_p0) : 32'd0;

    // Writeback side
    assign out_valid    = (state == DONE);
    assign out_rdata    = (out_valid && !fault_p0 && !is_store_p0)
                          ? extract(op_p0, addr_p0[1:0], rdata_p0) : 32'd0;
    assign out_adel     = out_valid && fault_p0 && !is_store_p0;
    assign out_ades     = out_valid && fault_p0 && is_store_p0;
    assign out_badvaddr = (out_valid && fault_p0) ? addr_p0 : 32'd0;

endmodule

// File: tb/tb_mem_data_access.sv
// Bench for mem_data_access: directed cases plus randomized ops against a
// byte-arithmetic reference model.
module tb_mem_data_access;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_alu_result;
    logic [31:0] in_store_data;
    logic [2:0]  in_mem_op;
    logic        in_flush;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rdata;
    logic        out_adel;
    logic        out_ades;
    logic [31:0] out_badvaddr;

    int total = 0;
    int bad   = 0;

    mem_data_access dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_result(in_alu_result), .in_store_data(in_store_data),
        .in_mem_op(in_mem_op), .in_flush(in_flush),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
        .out_adel(out_adel), .out_ades(out_ades), .out_badvaddr(out_badvaddr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: access width in bytes and plain shift/mask arithmetic.
    function automatic int op_bytes(input logic [2:0] op);
        if (op == 3'd0 || op == 3'd1 || op == 3'd5) return 1;
        if (op == 3'd2 || op == 3'd3 || op == 3'd6) return 2;
        return 4;
    endfunction

    function automatic logic m_misaligned(input logic [2:0] op, input logic [31:0] addr);
        return (addr % op_bytes(op)) != 0;
    endfunction

    function automatic logic [31:0] m_size(input logic [2:0] op);
        int n;
        n = op_bytes(op);
        return (n == 1) ? 32'd0 : (n == 2) ? 32'd1 : 32'd2;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] op, input logic [31:0] st);
        if (op == 3'd5) return (st & 32'hFF) * 32'h0101_0101;
        if (op == 3'd6) return (st & 32'hFFFF) * 32'h0001_0001;
        return st;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] op, input logic [31:0] addr,
                                           input logic [31:0] rd);
        logic [31:0] b, h;
        b = (rd >> (8 * (addr % 4))) & 32'hFF;
        h = (rd >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
        case (op)
            3'd0:    return (b >= 128) ? b - 32'd256 : b;
            3'd1:    return b;
            3'd2:    return (h >= 32768) ? h - 32'd65536 : h;
            3'd3:    return h;
            default: return rd;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] st,
                          input logic [31:0] rd, input int aok_dly, input int dok_dly,
                          input int rdy_dly);
        logic        mis, is_st;
        logic [31:0] exp_rd;
        mis   = m_misaligned(op, addr);
        is_st = (op >= 3'd5);
        chk("in_ready_idle", in_ready, 1);
        in_valid      = 1'b1;
        in_mem_op     = op;
        in_alu_result = addr;
        in_store_data = st;
        step();
        in_valid      = 1'b0;
        in_alu_result = $urandom;
        in_store_data = $urandom;
        in_mem_op     = 3'($urandom_range(0, 7));
        if (!mis) begin
            for (int i = 0; i <= aok_dly; i++) begin
                chk("req_high", data_req, 1);
                chk("req_wr", data_wr, is_st);
                chk("req_size", data_size, m_size(op));
                chk("req_addr", data_addr, addr);
                if (is_st) chk("req_wdata", data_wdata, m_wdata(op, st));
                chk("busy_in_ready", in_ready, 0);
                chk("req_no_valid", out_valid, 0);
                if (i == aok_dly) begin
                    data_addr_ok = 1'b1;
                    data_data_ok = (dok_dly == 0);
                    data_rdata   = (dok_dly == 0) ? rd : $urandom;
                end
                step();
            end
            data_addr_ok = 1'b0;
            data_data_ok = 1'b0;
            for (int i = 1; i <= dok_dly; i++) begin
                chk("wait_no_req", data_req, 0);
                chk("wait_no_valid", out_valid, 0);
                if (i == dok_dly) begin
                    data_data_ok = 1'b1;
                    data_rdata   = rd;
                end
                step();
            end
            data_data_ok = 1'b0;
            data_rdata   = $urandom;
        end
        exp_rd = (mis || is_st) ? 32'd0 : m_load(op, addr, rd);
        for (int i = 0; i <= rdy_dly; i++) begin
            chk("done_valid", out_valid, 1);
            chk("done_no_req", data_req, 0);
            chk("done_rdata", out_rdata, exp_rd);
            chk("done_adel", out_adel, mis && !is_st);
            chk("done_ades", out_ades, mis && is_st);
            chk("done_badvaddr", out_badvaddr, mis ? addr : 32'd0);
            chk("done_in_ready", in_ready, 0);
            if (i == rdy_dly) out_ready = 1'b1;
            step();
        end
        out_ready = 1'b0;
        chk("back_idle", in_ready, 1);
        chk("back_no_valid", out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] addr;
        resetn = 1'b0; in_valid = 1'b0; in_alu_result = '0; in_store_data = '0;
        in_mem_op = '0; in_flush = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
        data_rdata = '0; out_ready = 1'b0;
        repeat (3) step();

        chk("rst_in_ready", in_ready, 1);
        chk("rst_req", data_req, 0);
        chk("rst_wr", data_wr, 0);
        chk("rst_size", data_size, 0);
        chk("rst_addr", data_addr, 0);
        chk("rst_wdata", data_wdata, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_rdata", out_rdata, 0);
        chk("rst_adel", out_adel, 0);
        chk("rst_ades", out_ades, 0);
        chk("rst_badvaddr", out_badvaddr, 0);
        resetn = 1'b1;
        step();

        // Directed loads/stores and faults
        run_op(3'd4, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 0, 0, 0);
        run_op(3'd0, 32'h0000_1003, 32'h0, 32'h80FF_0000, 0, 0, 0);
        run_op(3'd1, 32'h0000_1003, 32'h0, 32'h80FF_0000, 0, 0, 0);
        run_op(3'd2, 32'h0000_1002, 32'h0, 32'h80FF_0000, 0, 0, 0);
        run_op(3'd6, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 3, 1, 1);
        run_op(3'd4, 32'h0000_3001, 32'h0, 32'h0, 0, 0, 0);
        run_op(3'd6, 32'h0000_3003, 32'h5555_5555, 32'h0, 0, 0, 2);

        // Flush while waiting for data_ok: result dropped
        in_valid = 1'b1; in_mem_op = 3'd4; in_alu_result = 32'h0000_4000;
        step();
        in_valid = 1'b0;
        chk("fw_req", data_req, 1);
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0;
        chk("fw_wait_no_req", data_req, 0);
        in_flush = 1'b1;
        step();
        in_flush = 1'b0;
        chk("fw_no_valid0", out_valid, 0);
        chk("fw_busy", in_ready, 0);
        step();
        chk("fw_no_valid1", out_valid, 0);
        data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
        step();
        data_data_ok = 1'b0;
        chk("fw_in_ready", in_ready, 1);
        chk("fw_no_valid2", out_valid, 0);
        step();
        chk("fw_no_valid3", out_valid, 0);

        // Flush before addr_ok: request withdrawn
        in_valid = 1'b1; in_mem_op = 3'd7; in_alu_result = 32'h0000_5000;
        step();
        in_valid = 1'b0;
        chk("fr_req", data_req, 1);
        in_flush = 1'b1;
        step();
        in_flush = 1'b0;
        chk("fr_no_req", data_req, 0);
        chk("fr_in_ready", in_ready, 1);
        chk("fr_no_valid", out_valid, 0);

        // Flush in DONE: result dropped
        in_valid = 1'b1; in_mem_op = 3'd4; in_alu_result = 32'h0000_6000;
        step();
        in_valid = 1'b0;
        data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h1111_2222;
        step();
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        chk("fd_valid", out_valid, 1);
        in_flush = 1'b1;
        step();
        in_flush = 1'b0;
        chk("fd_dropped", out_valid, 0);
        chk("fd_in_ready", in_ready, 1);

        // Asynchronous reset in REQ
        in_valid = 1'b1; in_mem_op = 3'd4; in_alu_result = 32'h0000_7000;
        step();
        in_valid = 1'b0;
        chk("rr_req", data_req, 1);
        resetn = 1'b0;
        #1;
        chk("rr_req_drop", data_req, 0);
        chk("rr_in_ready", in_ready, 1);
        chk("rr_no_valid", out_valid, 0);
        step();
        resetn = 1'b1;
        step();
        chk("rr_no_valid_after", out_valid, 0);
        run_op(3'd4, 32'h0000_7004, 32'h0, 32'h0BAD_F00D, 1, 2, 0);

        // Randomized ops
        repeat (80) begin
            op   = 3'($urandom_range(0, 7));
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr = addr - (addr % op_bytes(op));
            run_op(op, addr, $urandom, $urandom, $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
